// File: rtl/ysyx_23060096_wbu_if.sv
// Result channels from EXU/LSU and the register-file write port of the write-back unit.
// The master side produces results and consumes writes; the WBU is the slave.
interface ysyx_23060096_wbu_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      exu_valid;
  logic                      exu_ready;
  logic [REG_ADDR_WIDTH-1:0] exu_rd;
  logic [DATA_WIDTH-1:0]     exu_data;

  logic                      lsu_valid;
  logic                      lsu_ready;
  logic [REG_ADDR_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0]     lsu_rdata;
  logic [2:0]                lsu_funct3;
  logic [1:0]                lsu_addr_lo;

  logic                      rf_hold;
  logic                      rf_w_en;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0]     rf_wdata;

  modport master (
    output exu_valid, exu_rd, exu_data,
    output lsu_valid, lsu_rd, lsu_rdata, lsu_funct3, lsu_addr_lo,
    output rf_hold,
    input  exu_ready, lsu_ready,
    input  rf_w_en, rf_waddr, rf_wdata
  );

  modport slave (
    input  exu_valid, exu_rd, exu_data,
    input  lsu_valid, lsu_rd, lsu_rdata, lsu_funct3, lsu_addr_lo,
    input  rf_hold,
    output exu_ready, lsu_ready,
    output rf_w_en, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/ysyx_23060096_wbu.sv
// Write-back unit: arbitrates EXU/LSU results (LSU first), formats loads, and drains an
// in-order FIFO into the register-file write port; also reports pending-write hazards.
module ysyx_23060096_wbu #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DEPTH          = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  ysyx_23060096_wbu_if.slave        bus,
  input  logic [REG_ADDR_WIDTH-1:0] hz_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] hz_rs2,
  output logic                      hz_busy1,
  output logic                      hz_busy2,
  output logic [63:0]               retire_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic [REG_ADDR_WIDTH-1:0] rd_mem   [DEPTH];
  logic [DATA_WIDTH-1:0]     data_mem [DEPTH];
  logic [DEPTH-1:0]          entry_vld;
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CNT_W-1:0]          count;

  logic                      full;
  logic                      empty;
  logic                      lsu_fire;
  logic                      exu_fire;
  logic                      accept;
  logic                      push;
  logic                      pop;
  logic [REG_ADDR_WIDTH-1:0] in_rd;
  logic [DATA_WIDTH-1:0]     in_data;
  logic [DATA_WIDTH-1:0]     load_data;
  logic [7:0]                ld_byte;
  logic [15:0]               ld_half;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Full is judged on registered occupancy, so a same-cycle pop never opens a slot.
  assign bus.lsu_ready = !full;
  assign bus.exu_ready = !full && !bus.lsu_valid;

  assign lsu_fire = bus.lsu_valid && bus.lsu_ready;
  assign exu_fire = bus.exu_valid && bus.exu_ready;
  assign accept   = lsu_fire || exu_fire;

  assign ld_byte = bus.lsu_rdata[{bus.lsu_addr_lo, 3'b000} +: 8];
  assign ld_half = bus.lsu_rdata[{bus.lsu_addr_lo[1], 4'b0000} +: 16];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    load_data = bus.lsu_rdata;
    unique case (bus.lsu_funct3)
      F3_LB:   load_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      F3_LH:   load_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      F3_LBU:  load_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      F3_LHU:  load_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      default: load_data = bus.lsu_rdata;
    endcase
  end

  assign in_rd   = lsu_fire ? bus.lsu_rd : bus.exu_rd;
  assign in_data = lsu_fire ? load_data  : bus.exu_data;

  // Writes to x0 retire but never occupy a FIFO slot.
  assign push = accept && (in_rd != '0);
  assign pop  = !empty && !bus.rf_hold;

  assign bus.rf_w_en  = pop;
  assign bus.rf_waddr = empty ? '0 : rd_mem[rd_ptr];
  assign bus.rf_wdata = empty ? '0 : data_mem[rd_ptr];

  // NOTE: the payload storage is not reset; entry_vld and count alone define what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= in_rd;
      data_mem[wr_ptr] <= in_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      entry_vld  <= '0;
      retire_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr            <= wr_ptr + PTR_W'(1);
        entry_vld[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr            <= rd_ptr + PTR_W'(1);
        entry_vld[rd_ptr] <= 1'b0;
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (accept) begin
        retire_cnt <= retire_cnt + 64'd1;
      end
    end
  end

  always_comb begin
    hz_busy1 = 1'b0;
    hz_busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld[i] && (rd_mem[i] == hz_rs1)) hz_busy1 = 1'b1;
      if (entry_vld[i] && (rd_mem[i] == hz_rs2)) hz_busy2 = 1'b1;
    end
    if (hz_rs1 == '0) hz_busy1 = 1'b0;
    if (hz_rs2 == '0) hz_busy2 = 1'b0;
  end

endmodule
